// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared router definitions: port numbering, widths and the allocator state
// type used by the switch allocator and its round-robin arbiter.
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam int NUM_PORTS = 5;
   localparam int PORT_ID_W = 3;
   localparam int CNT_WIDTH = 16;

   typedef logic [PORT_ID_W-1:0] port_id_t;

   localparam port_id_t LOCAL = 3'd0;
   localparam port_id_t WEST  = 3'd1;
   localparam port_id_t NORTH = 3'd2;
   localparam port_id_t EAST  = 3'd3;
   localparam port_id_t SOUTH = 3'd4;

   typedef enum logic {IDLE, LOCKED} alloc_state_t;

   // Next port index, wrapping SOUTH back to LOCAL.
   function automatic port_id_t next_port(input port_id_t p);
      return (p == port_id_t'(NUM_PORTS - 1)) ? '0 : port_id_t'(p + 3'd1);
   endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// ptr and wraps, so the last winner has the lowest priority.
//   req   : request vector, one bit per input port
//   ptr   : index of the previous winner
//   grant : one-hot winner (all zero when req is zero)
//   idx   : encoded winner index (0 when req is zero)
//   any   : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
   import noc_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  port_id_t             ptr,
   output logic [NUM_PORTS-1:0] grant,
   output port_id_t             idx,
   output logic                 any
);

   port_id_t cand;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = next_port(cand);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Per-output wormhole switch allocator. Each output runs an IDLE/LOCKED FSM:
// in IDLE it picks one requesting input round-robin (one cycle, no transfer),
// in LOCKED it forwards the owner's flits until the tail flit is granted.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : input i has a flit at its buffer head
//   in_port    : requested output of input i, bits [3i+2:3i]
//   in_tail    : head flit of input i is a tail flit
//   out_ready  : downstream of output o can accept a flit
//   in_grant   : flit of input i transfers this cycle (buffer pop)
//   out_valid  : output o carries a flit this cycle
//   out_sel    : input index driving output o, bits [3o+2:3o]
//   req_err    : registered; a valid input requested port ID 5..7 last cycle
// Optional (macro SWITCH_ALLOC_PERF_CNT_EN):
//   flit_cnt, stall_cnt : saturating per-output transfer / stall counters
// -----------------------------------------------------------------------------
module switch_allocator
   import noc_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_PORTS-1:0]           in_valid,
   input  logic [NUM_PORTS*PORT_ID_W-1:0] in_port,
   input  logic [NUM_PORTS-1:0]           in_tail,
   input  logic [NUM_PORTS-1:0]           out_ready,
   output logic [NUM_PORTS-1:0]           in_grant,
   output logic [NUM_PORTS-1:0]           out_valid,
   output logic [NUM_PORTS*PORT_ID_W-1:0] out_sel,
   output logic                           req_err
`ifdef SWITCH_ALLOC_PERF_CNT_EN
   ,
   output logic [NUM_PORTS*CNT_WIDTH-1:0] flit_cnt,
   output logic [NUM_PORTS*CNT_WIDTH-1:0] stall_cnt
`endif
);

   alloc_state_t         state  [NUM_PORTS];
   port_id_t             owner  [NUM_PORTS];
   port_id_t             rr_ptr [NUM_PORTS];

   port_id_t             req_port [NUM_PORTS];
   logic [NUM_PORTS-1:0] match    [NUM_PORTS];
   logic [NUM_PORTS-1:0] req_set  [NUM_PORTS];
   logic [NUM_PORTS-1:0] arb_grant [NUM_PORTS];
   port_id_t             arb_idx  [NUM_PORTS];
   logic [NUM_PORTS-1:0] arb_any;
   logic [NUM_PORTS-1:0] busy;
   logic [NUM_PORTS-1:0] claimed;
   logic [NUM_PORTS-1:0] bad_id;
   logic [NUM_PORTS-1:0] xfer;

   // Decode requests and build each output's eligible request set.
   always_comb begin
      busy    = '0;
      claimed = '0;
      bad_id  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_port[i] = in_port[i*PORT_ID_W +: PORT_ID_W];
         bad_id[i]   = (req_port[i] >= port_id_t'(NUM_PORTS));
      end
      for (int o = 0; o < NUM_PORTS; o++)
         if (state[o] == LOCKED) busy[owner[o]] = 1'b1;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++)
            match[o][i] = in_valid[i] && (req_port[i] == port_id_t'(o));
         // Inputs owning an output are excluded, and anything seen by a
         // lower-index IDLE output is reserved for that output.
         req_set[o] = match[o] & ~busy & ~claimed;
         if (state[o] == IDLE) claimed = claimed | match[o];
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter u_arb (
         .req   (req_set[o]),
         .ptr   (rr_ptr[o]),
         .grant (arb_grant[o]),
         .idx   (arb_idx[o]),
         .any   (arb_any[o])
      );
   end

   // Datapath outputs follow the lock state; nothing transfers while rst_n is low.
   always_comb begin
      in_grant  = '0;
      out_valid = '0;
      out_sel   = '0;
      xfer      = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (rst_n && state[o] == LOCKED) begin
            out_valid[o] = in_valid[owner[o]] && (req_port[owner[o]] == port_id_t'(o));
            out_sel[o*PORT_ID_W +: PORT_ID_W] = owner[o];
            xfer[o] = out_valid[o] && out_ready[o];
            if (xfer[o]) in_grant[owner[o]] = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_err <= 1'b0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            state[o]  <= IDLE;
            owner[o]  <= '0;
            rr_ptr[o] <= '0;
         end
      end else begin
         req_err <= |(in_valid & bad_id);
         for (int o = 0; o < NUM_PORTS; o++) begin
            case (state[o])
               IDLE: if (arb_any[o]) begin
                  owner[o] <= arb_idx[o];
                  state[o] <= LOCKED;
               end
               LOCKED: if (xfer[o] && in_tail[owner[o]]) begin
                  state[o]  <= IDLE;
                  rr_ptr[o] <= owner[o];
               end
               default: state[o] <= IDLE;
            endcase
         end
      end
   end

`ifdef SWITCH_ALLOC_PERF_CNT_EN
   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_cnt
      logic [CNT_WIDTH-1:0] f_cnt, s_cnt;
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            f_cnt <= '0;
            s_cnt <= '0;
         end else begin
            if (out_valid[o] && out_ready[o] && !(&f_cnt)) f_cnt <= f_cnt + 1'b1;
            if (out_valid[o] && !out_ready[o] && !(&s_cnt)) s_cnt <= s_cnt + 1'b1;
         end
      end
      assign flit_cnt[o*CNT_WIDTH +: CNT_WIDTH]  = f_cnt;
      assign stall_cnt[o*CNT_WIDTH +: CNT_WIDTH] = s_cnt;
   end
`endif

endmodule
